// File: rtl/dbg_view_scan.sv
// ============================================================================
// Module   : dbg_view_scan
// Purpose  : Steps through per-channel debug entries, reads each from a source
//            and presents it as a display word with a one-cycle valid pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbg_view_scan #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int DIV_W    = 28,
  parameter int FAST_TAP = 25,
  parameter int SLOW_TAP = 27,
  parameter int TO_CYC   = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_CH-1:0]                           ch_sel,
  input  logic [NUM_CH*ADDR_W-1:0]                    ch_depth,
  input  logic                                        auto_en,
  input  logic                                        slow,
  input  logic                                        step_i,
  input  logic                                        hold,
  output logic                                        rd_req,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_ch,
  output logic [ADDR_W-1:0]                           rd_addr,
  input  logic                                        rd_ack,
  input  logic [DATA_W-1:0]                           rd_data,
  output logic [DATA_W-1:0]                           disp_data,
  output logic                                        disp_valid,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] disp_ch,
  output logic [ADDR_W-1:0]                           disp_addr,
  output logic                                        err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TO_CYC + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                fast_tap_q, fast_tap_d;
  logic                slow_tap_q, slow_tap_d;
  logic                step_q, step_d;
  logic                step_prev_q, step_prev_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic                abort_q, abort_d;
  logic [CNT_W-1:0]    to_cnt_q, to_cnt_d;
  logic                rd_req_q, rd_req_d;
  logic [CH_W-1:0]     rd_ch_q, rd_ch_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_valid_q, disp_valid_d;
  logic [CH_W-1:0]     disp_ch_q, disp_ch_d;
  logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
  logic                err_q, err_d;

  logic                onehot;
  logic [CH_W-1:0]     hot_idx;
  logic [CH_W-1:0]     act_ch;
  logic [ADDR_W-1:0]   depth;
  logic                auto_step;
  logic                man_step;
  logic                step;
  logic                ch_chg;
  logic [ADDR_W-1:0]   eff_addr;
  logic                abort_now;
  logic                done;

  // Malformed selects (none or several bits) fall back to channel 0.
  always_comb begin
    hot_idx = '0;
    onehot  = (ch_sel != '0) && ((ch_sel & (ch_sel - NUM_CH'(1))) == '0);
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel[k]) hot_idx = CH_W'(k);
    end
    act_ch = onehot ? hot_idx : '0;
    depth  = ch_depth[act_ch*ADDR_W +: ADDR_W];
  end

  // Each tap has its own history so toggling slow cannot fake a rising edge.
  always_comb begin
    auto_step = slow ? (div_q[SLOW_TAP] & ~slow_tap_q)
                     : (div_q[FAST_TAP] & ~fast_tap_q);
    man_step  = step_q & ~step_prev_q;
    step      = (auto_en ? auto_step : man_step) & ~hold;
    ch_chg    = (act_ch != ch_q);
    eff_addr  = ch_chg ? '0 : cur_addr_q;
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q + 1'b1;
    fast_tap_d   = div_q[FAST_TAP];
    slow_tap_d   = div_q[SLOW_TAP];
    step_d       = step_i;
    step_prev_d  = step_q;
    cur_addr_d   = cur_addr_q;
    ch_d         = act_ch;
    abort_d      = abort_q;
    to_cnt_d     = to_cnt_q;
    rd_req_d     = rd_req_q;
    rd_ch_d      = rd_ch_q;
    rd_addr_d    = rd_addr_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    disp_ch_d    = disp_ch_q;
    disp_addr_d  = disp_addr_q;
    err_d        = err_q;
    abort_now    = 1'b0;
    done         = 1'b0;

    case (state_q)
      IDLE: begin
        if (ch_chg) cur_addr_d = '0;
        if (step) begin
          if (eff_addr < depth) begin
            rd_req_d  = 1'b1;
            rd_ch_d   = act_ch;
            rd_addr_d = eff_addr;
            to_cnt_d  = '0;
            abort_d   = 1'b0;
            state_d   = REQ;
          end else if (eff_addr == depth) begin
            disp_data_d  = '1;
            disp_valid_d = 1'b1;
            disp_ch_d    = act_ch;
            disp_addr_d  = depth;
            cur_addr_d   = '0;
          end else begin
            // Depth shrank below the cursor: restart the scan.
            cur_addr_d = '0;
          end
        end
      end

      REQ: begin
        abort_now = abort_q | (act_ch != rd_ch_q);
        abort_d   = abort_now;
        done      = rd_ack | (to_cnt_q == CNT_W'(TO_CYC - 1));
        if (done) begin
          rd_req_d = 1'b0;
          state_d  = IDLE;
          if (abort_now) begin
            cur_addr_d = '0;
          end else begin
            cur_addr_d   = rd_addr_q + 1'b1;
            disp_valid_d = 1'b1;
            disp_ch_d    = rd_ch_q;
            disp_addr_d  = rd_addr_q;
            if (rd_ack) begin
              disp_data_d = rd_data;
            end else begin
              disp_data_d = '1;
              err_d       = 1'b1;
            end
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_q        <= '0;
      fast_tap_q   <= 1'b0;
      slow_tap_q   <= 1'b0;
      step_q       <= 1'b0;
      step_prev_q  <= 1'b0;
      cur_addr_q   <= '0;
      ch_q         <= '0;
      abort_q      <= 1'b0;
      to_cnt_q     <= '0;
      rd_req_q     <= 1'b0;
      rd_ch_q      <= '0;
      rd_addr_q    <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      disp_ch_q    <= '0;
      disp_addr_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      fast_tap_q   <= fast_tap_d;
      slow_tap_q   <= slow_tap_d;
      step_q       <= step_d;
      step_prev_q  <= step_prev_d;
      cur_addr_q   <= cur_addr_d;
      ch_q         <= ch_d;
      abort_q      <= abort_d;
      to_cnt_q     <= to_cnt_d;
      rd_req_q     <= rd_req_d;
      rd_ch_q      <= rd_ch_d;
      rd_addr_q    <= rd_addr_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      disp_ch_q    <= disp_ch_d;
      disp_addr_q  <= disp_addr_d;
      err_q        <= err_d;
    end
  end

  assign rd_req     = rd_req_q;
  assign rd_ch      = rd_ch_q;
  assign rd_addr    = rd_addr_q;
  assign disp_data  = disp_data_q;
  assign disp_valid = disp_valid_q;
  assign disp_ch    = disp_ch_q;
  assign disp_addr  = disp_addr_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dbg_view_scan.sv
// ============================================================================
// Module   : tb_dbg_view_scan
// Purpose  : Directed self-checking bench for dbg_view_scan.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbg_view_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ch_sel;
  logic [23:0] ch_depth;
  logic        auto_en, slow, step_i, hold;
  logic        rd_req;
  logic [1:0]  rd_ch;
  logic [5:0]  rd_addr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [31:0] disp_data;
  logic        disp_valid;
  logic [1:0]  disp_ch;
  logic [5:0]  disp_addr;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  dbg_view_scan #(
    .NUM_CH(4), .ADDR_W(6), .DATA_W(32), .DIV_W(6),
    .FAST_TAP(2), .SLOW_TAP(4), .TO_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .ch_sel(ch_sel), .ch_depth(ch_depth),
    .auto_en(auto_en), .slow(slow), .step_i(step_i), .hold(hold),
    .rd_req(rd_req), .rd_ch(rd_ch), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_data(rd_data),
    .disp_data(disp_data), .disp_valid(disp_valid), .disp_ch(disp_ch),
    .disp_addr(disp_addr), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench on the falling edge after the step has been acted on.
  task automatic pulse_step;
    step_i = 1'b1;
    tick;
    step_i = 1'b0;
    tick;
  endtask

  task automatic ack_now(input logic [31:0] d);
    rd_ack  = 1'b1;
    rd_data = d;
    tick;
    rd_ack  = 1'b0;
  endtask

  logic [31:0] vals [3];
  int n, t0, t1, cnt;

  initial begin
    vals[0] = 32'hAAAA_0001;
    vals[1] = 32'hBBBB_0002;
    vals[2] = 32'hCCCC_0003;
    rst = 1'b1; ch_sel = 4'b0001; ch_depth = {6'd0, 6'd2, 6'd0, 6'd3};
    auto_en = 1'b0; slow = 1'b0; step_i = 1'b0; hold = 1'b0;
    rd_ack = 1'b0; rd_data = '0;
    tick; tick;
    chk("reset_rd_req", rd_req, 1'b0);
    chk("reset_disp_valid", disp_valid, 1'b0);
    chk("reset_disp_data", disp_data, 32'h0);
    chk("reset_err", err, 1'b0);
    rst = 1'b0;
    tick;

    // Three reads with one idle REQ cycle, then the end marker.
    for (int i = 0; i < 3; i++) begin
      pulse_step;
      chk("man_rd_req", rd_req, 1'b1);
      chk("man_rd_addr", rd_addr, i);
      chk("man_rd_ch", rd_ch, 2'd0);
      tick;
      ack_now(vals[i]);
      chk("man_disp_valid", disp_valid, 1'b1);
      chk("man_disp_data", disp_data, vals[i]);
      chk("man_disp_addr", disp_addr, i);
      chk("man_rd_req_low", rd_req, 1'b0);
    end
    pulse_step;
    chk("end_disp_valid", disp_valid, 1'b1);
    chk("end_disp_data", disp_data, 32'hFFFF_FFFF);
    chk("end_disp_addr", disp_addr, 6'd3);
    chk("end_no_req", rd_req, 1'b0);

    // Same-cycle ack: wrap back to entry 0, valid two edges after the step edge.
    pulse_step;
    chk("fast_rd_addr", rd_addr, 6'd0);
    chk("fast_no_valid_yet", disp_valid, 1'b0);
    ack_now(32'hDDDD_0004);
    chk("fast_disp_valid", disp_valid, 1'b1);
    chk("fast_disp_data", disp_data, 32'hDDDD_0004);
    tick;
    chk("fast_valid_one_cycle", disp_valid, 1'b0);

    // Timeout from a fresh start.
    rst = 1'b1; tick; rst = 1'b0; tick;
    pulse_step;
    n = 0;
    while (rd_req && n < 40) begin n++; tick; end
    chk("to_req_cycles", n, 16);
    chk("to_disp_valid", disp_valid, 1'b1);
    chk("to_disp_data", disp_data, 32'hFFFF_FFFF);
    chk("to_err", err, 1'b1);
    chk("to_disp_addr", disp_addr, 6'd0);
    pulse_step;
    chk("to_next_addr", rd_addr, 6'd1);
    ack_now(32'h1111_2222);
    chk("to_next_data", disp_data, 32'h1111_2222);
    chk("err_sticky", err, 1'b1);

    // Channel change during REQ discards the read.
    pulse_step;
    chk("chg_rd_addr", rd_addr, 6'd2);
    ch_sel = 4'b0100;
    tick; tick; tick;
    ack_now(32'h5555_5555);
    chk("chg_no_valid", disp_valid, 1'b0);
    chk("chg_req_low", rd_req, 1'b0);
    pulse_step;
    chk("chg_new_ch", rd_ch, 2'd2);
    chk("chg_new_addr", rd_addr, 6'd0);
    ack_now(32'h6666_6666);
    chk("chg_disp_ch", disp_ch, 2'd2);

    // Two bits set selects channel 0, restarting at entry 0.
    ch_sel = 4'b0110;
    tick;
    pulse_step;
    chk("multi_rd_ch", rd_ch, 2'd0);
    chk("multi_rd_addr", rd_addr, 6'd0);
    ack_now(32'h7777_7777);

    // Depth drops under the cursor, then depth 0 yields only markers.
    ch_depth = {6'd0, 6'd2, 6'd0, 6'd0};
    pulse_step;
    chk("shrink_no_req", rd_req, 1'b0);
    chk("shrink_no_valid", disp_valid, 1'b0);
    pulse_step;
    chk("d0_no_req", rd_req, 1'b0);
    chk("d0_valid", disp_valid, 1'b1);
    chk("d0_data", disp_data, 32'hFFFF_FFFF);
    chk("d0_addr", disp_addr, 6'd0);

    // Hold discards manual steps.
    ch_depth = {6'd0, 6'd2, 6'd0, 6'd3};
    hold = 1'b1;
    pulse_step;
    chk("hold_no_req", rd_req, 1'b0);
    chk("hold_no_valid", disp_valid, 1'b0);
    hold = 1'b0;
    tick;

    // Reset during REQ drops everything asynchronously.
    ch_sel = 4'b0001;
    pulse_step;
    chk("rr_req_up", rd_req, 1'b1);
    tick;
    rst = 1'b1;
    #1;
    chk("rr_req_low", rd_req, 1'b0);
    chk("rr_disp_data", disp_data, 32'h0);
    chk("rr_err", err, 1'b0);
    chk("rr_disp_addr", disp_addr, 6'd0);
    tick;
    rst = 1'b0;
    tick;
    chk("rr_no_stale_valid", disp_valid, 1'b0);
    pulse_step;
    chk("rr_rd_ch", rd_ch, 2'd0);
    chk("rr_rd_addr", rd_addr, 6'd0);
    ack_now(32'h8888_8888);

    // Auto pacing on divider bit 2: one step every 8 cycles.
    ch_depth = {6'd0, 6'd2, 6'd0, 6'd63};
    auto_en = 1'b1;
    rd_ack  = 1'b1;
    rd_data = 32'h9999_9999;
    for (int i = 0; i < 20 && !rd_req; i++) tick;
    chk("auto_first_req", rd_req, 1'b1);
    t0 = cyc;
    tick;
    for (int i = 0; i < 20 && !rd_req; i++) tick;
    chk("auto_second_req", rd_req, 1'b1);
    t1 = cyc;
    chk("auto_period", t1 - t0, 8);
    hold = 1'b1;
    tick;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (rd_req) cnt++;
      tick;
    end
    chk("auto_hold_no_req", cnt, 0);
    hold = 1'b0;
    for (int i = 0; i < 12 && !rd_req; i++) tick;
    chk("auto_resume_req", rd_req, 1'b1);
    rd_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
